// File: rtl/mult_arbiter.sv
// Round-robin front end that time-shares one sequential 8x8 multiplier between
// up to four requesters, with a watchdog that turns a stuck job into an error response.
module mult_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_valid_i,
    output logic [N-1:0]     req_ready_o,
    input  logic [8*N-1:0]   req_a_i,
    input  logic [8*N-1:0]   req_b_i,
    output logic [N-1:0]     rsp_valid_o,
    input  logic [N-1:0]     rsp_ready_i,
    output logic [15:0]      rsp_y_o,
    output logic             rsp_err_o,
    output logic             mult_start_o,
    output logic [7:0]       mult_a_o,
    output logic [7:0]       mult_b_o,
    input  logic             mult_busy_i,
    input  logic [15:0]      mult_y_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_gnt;
    logic [7:0]    r_wdog;
    logic [N-1:0]  r_rsp_valid;
    logic [15:0]   r_y;
    logic          r_err;
    logic          r_start;
    logic [7:0]    r_a;
    logic [7:0]    r_b;

    // Requester inputs padded to four lanes so lane indices are always 2 bits wide.
    logic [3:0]    w_valid_pad;
    logic [7:0]    w_a_pad [4];
    logic [7:0]    w_b_pad [4];
    logic [N-1:0]  w_gnt_oh;
    logic [N-1:0]  w_rgnt_oh;
    logic          w_found;
    logic [1:0]    w_gnt;
    logic          w_accept;
    logic          w_rsp_hs;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < N) begin : g_used
                assign w_valid_pad[gi] = req_valid_i[gi];
                assign w_a_pad[gi]     = req_a_i[8*gi +: 8];
                assign w_b_pad[gi]     = req_b_i[8*gi +: 8];
            end else begin : g_unused
                assign w_valid_pad[gi] = 1'b0;
                assign w_a_pad[gi]     = 8'd0;
                assign w_b_pad[gi]     = 8'd0;
            end
        end
        for (genvar gi = 0; gi < N; gi++) begin : g_oh
            assign w_gnt_oh[gi]  = w_accept && (w_gnt == 2'(gi));
            assign w_rgnt_oh[gi] = (r_gnt == 2'(gi));
        end
    endgenerate

    // Search upward from ptr+1 with wrap-around; the first valid lane wins.
    always_comb begin
        logic [2:0] idx;
        w_found = 1'b0;
        w_gnt   = 2'd0;
        idx     = 3'd0;
        for (int k = 1; k <= N; k++) begin
            idx = {1'b0, r_ptr} + 3'(k);
            if (idx >= 3'(N)) begin
                idx = idx - 3'(N);
            end
            if (!w_found && w_valid_pad[idx[1:0]]) begin
                w_found = 1'b1;
                w_gnt   = idx[1:0];
            end
        end
    end

    assign w_accept = rst_ni && (r_state == S_IDLE) && !mult_busy_i && w_found;
    assign w_rsp_hs = |(r_rsp_valid & rsp_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'(N-1);
            r_gnt       <= 2'd0;
            r_wdog      <= 8'd0;
            r_rsp_valid <= '0;
            r_y         <= 16'd0;
            r_err       <= 1'b0;
            r_start     <= 1'b0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_a_pad[w_gnt];
                        r_b     <= w_b_pad[w_gnt];
                        r_gnt   <= w_gnt;
                        r_ptr   <= w_gnt;
                        r_start <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + 8'd1;
                    if (!mult_busy_i) begin
                        r_y         <= mult_y_i;
                        r_err       <= 1'b0;
                        r_rsp_valid <= w_rgnt_oh;
                        r_state     <= S_RESP;
                    end else if (r_wdog == 8'(TIMEOUT-1)) begin
                        r_y         <= 16'd0;
                        r_err       <= 1'b1;
                        r_rsp_valid <= w_rgnt_oh;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Only the granted lane's ready can complete the response.
                    if (w_rsp_hs) begin
                        r_rsp_valid <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o  = w_gnt_oh;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_y_o      = r_y;
    assign rsp_err_o    = r_err;
    assign mult_start_o = r_start;
    assign mult_a_o     = r_a;
    assign mult_b_o     = r_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a behavioural multiplier stub, directed jobs
// with hand-computed products, and a negedge monitor that checks every response.
module tb_mult_arbiter;
    localparam int N       = 2;
    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req_a = 16'd0;
    logic [15:0] req_b = 16'd0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic [15:0] rsp_y;
    logic        rsp_err;
    logic        m_start;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic        m_busy;
    logic [15:0] m_y;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int hs_cyc = 0;
    int start_cnt = 0;
    int rsp_cnt = 0;

    typedef struct {
        int          idx;
        logic [15:0] y;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   acc_idx_q[$];
    int   acc_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_y_o      (rsp_y),
        .rsp_err_o    (rsp_err),
        .mult_start_o (m_start),
        .mult_a_o     (m_a),
        .mult_b_o     (m_b),
        .mult_busy_i  (m_busy),
        .mult_y_i     (m_y)
    );

    // Multiplier stub: busy for 8 cycles after start; hang freezes it, kill clears it.
    logic        s_busy = 1'b0;
    logic [3:0]  s_cnt = 4'd0;
    logic [15:0] s_y = 16'd0;
    logic        hang = 1'b0;
    logic        kill = 1'b0;

    always @(posedge clk) begin
        if (kill) begin
            s_busy <= 1'b0;
        end else if (m_start) begin
            s_busy <= 1'b1;
            s_cnt  <= 4'd7;
            s_y    <= 16'(m_a) * 16'(m_b);
        end else if (s_busy && !hang) begin
            if (s_cnt == 4'd0) s_busy <= 1'b0;
            else               s_cnt  <= s_cnt - 4'd1;
        end
    end
    assign m_busy = s_busy;
    assign m_y    = s_y;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int idx, logic [15:0] y, logic err, int lat);
        exp_t e;
        e.idx = idx; e.y = y; e.err = err; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic set_ops(bit k, logic [7:0] a, logic [7:0] b);
        if (k) begin req_a[15:8] = a; req_b[15:8] = b; end
        else   begin req_a[7:0]  = a; req_b[7:0]  = b; end
    endtask

    task automatic reset_outputs_chk();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_start", 32'(m_start), 32'd0);
        chk("rst_mult_a", 32'(m_a), 32'd0);
        chk("rst_mult_b", 32'(m_b), 32'd0);
    endtask

    task automatic await_accept(bit k, logic [7:0] a, logic [7:0] b);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (req_ready[k]) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout: requester %0d never granted, req_ready=%b", k, req_ready);
            req_valid[k] = 1'b0;
            return;
        end
        chk("ready_onehot", 32'(req_ready), k ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        @(negedge clk);
        chk("issue_start", 32'(m_start), 32'd1);
        chk("issue_a", 32'(m_a), 32'(a));
        chk("issue_b", 32'(m_b), 32'(b));
    endtask

    task automatic send(bit k, logic [7:0] a, logic [7:0] b);
        @(posedge clk); #1;
        set_ops(k, a, b);
        req_valid[k] = 1'b1;
        await_accept(k, a, b);
    endtask

    task automatic wait_rsp(int target);
        for (int i = 0; i < 400 && rsp_cnt < target; i++) @(negedge clk);
        chk("rsp_count", 32'(rsp_cnt), 32'(target));
    endtask

    task automatic wait_acc(int target);
        for (int i = 0; i < 400 && acc_idx_q.size() < target; i++) @(negedge clk);
        chk("accept_count", 32'(acc_idx_q.size()), 32'(target));
    endtask

    // Monitor: logs accepts and starts, checks each response against the scoreboard head.
    initial begin
        bit prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
                continue;
            end
            if ((req_valid & req_ready) != 2'b00) begin
                acc_idx_q.push_back(req_ready[1] ? 1 : 0);
                acc_cyc_q.push_back(cyc);
                last_acc = cyc;
            end
            if (m_start) begin
                start_cnt++;
                chk("start_while_busy", 32'(m_busy), 32'd0);
            end
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b y=%0h with nothing expected", rsp_valid, rsp_y);
                end else begin
                    if (!prev_v) begin
                        chk("rsp_lane", 32'(rsp_valid), 32'd1 << sb[0].idx);
                        chk("rsp_latency", 32'(cyc - last_acc), 32'(sb[0].lat));
                    end
                    chk("rsp_y", 32'(rsp_y), 32'(sb[0].y));
                    chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                    if ((rsp_valid & rsp_ready) != 2'b00) begin
                        hs_cyc = cyc;
                        void'(sb.pop_front());
                        rsp_cnt++;
                        $display("rsp %0d: lane=%b y=%0h err=%0b cycle=%0d", rsp_cnt, rsp_valid, rsp_y, rsp_err, cyc);
                    end
                end
            end
            prev_v = (rsp_valid != 2'b00);
        end
    end

    initial begin
        #200000;
        checks++; errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "global timeout");
    end

    initial begin
        int sc;
        bit bad;
        bit got;

        #1;
        reset_outputs_chk();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single job and operand extremes
        push(0, 16'd143, 1'b0, 11);
        send(1'b0, 8'd13, 8'd11);
        wait_rsp(1);
        push(0, 16'hFE01, 1'b0, 11);
        send(1'b0, 8'hFF, 8'hFF);
        wait_rsp(2);
        push(1, 16'd0, 1'b0, 11);
        send(1'b1, 8'd0, 8'hFF);
        wait_rsp(3);

        // Round-robin with both requesters held valid
        acc_idx_q.delete(); acc_cyc_q.delete();
        push(0, 16'd21, 1'b0, 11);
        push(1, 16'd200, 1'b0, 11);
        push(0, 16'd21, 1'b0, 11);
        push(1, 16'd200, 1'b0, 11);
        @(posedge clk); #1;
        set_ops(1'b0, 8'd3, 8'd7);
        set_ops(1'b1, 8'd10, 8'd20);
        req_valid = 2'b11;
        wait_acc(4);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(7);
        if (acc_idx_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("rr_order", 32'(acc_idx_q[i]), 32'(i % 2));
                if (i > 0) chk("rr_spacing", 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'd12);
            end
        end

        // Response backpressure with a pending second requester
        acc_idx_q.delete(); acc_cyc_q.delete();
        push(0, 16'd45, 1'b0, 11);
        push(1, 16'd16, 1'b0, 11);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        set_ops(1'b0, 8'd5, 8'd9);
        set_ops(1'b1, 8'd4, 8'd4);
        req_valid = 2'b11;
        wait_acc(1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) got = 1'b1;
        end
        chk("bp_rsp_seen", 32'(got), 32'd1);
        sc = start_cnt;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        repeat (10) @(negedge clk);
        chk("bp_no_start", 32'(start_cnt), 32'(sc));
        chk("bp_valid_held", 32'(rsp_valid), 32'd1);
        chk("bp_no_grant", 32'(acc_idx_q.size()), 32'd1);
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        wait_acc(2);
        if (acc_idx_q.size() >= 2) begin
            chk("bp_grant_lane", 32'(acc_idx_q[1]), 32'd1);
            chk("bp_grant_after_hs", 32'(acc_cyc_q[1] - hs_cyc), 32'd1);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(9);

        // Watchdog timeout, then a request held off until busy falls
        hang = 1'b1;
        push(0, 16'd0, 1'b1, TIMEOUT + 2);
        send(1'b0, 8'd5, 8'd6);
        wait_rsp(10);
        chk("to_busy_still_high", 32'(m_busy), 32'd1);
        push(1, 16'd56, 1'b0, 11);
        @(posedge clk); #1;
        set_ops(1'b1, 8'd7, 8'd8);
        req_valid[1] = 1'b1;
        sc = start_cnt;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (req_ready != 2'b00) bad = 1'b1;
        end
        chk("to_no_grant_while_busy", 32'(bad), 32'd0);
        chk("to_no_start_while_busy", 32'(start_cnt), 32'(sc));
        @(posedge clk); #1;
        hang = 1'b0;
        await_accept(1'b1, 8'd7, 8'd8);
        wait_rsp(11);

        // Asynchronous reset during WAIT; multiplier stays busy past release
        send(1'b0, 8'd9, 8'd9);
        repeat (3) @(negedge clk);
        #2;
        hang  = 1'b1;
        rst_n = 1'b0;
        #1;
        reset_outputs_chk();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        acc_idx_q.delete(); acc_cyc_q.delete();
        push(0, 16'd144, 1'b0, 11);
        push(1, 16'd200, 1'b0, 11);
        set_ops(1'b0, 8'd12, 8'd12);
        set_ops(1'b1, 8'd2, 8'd100);
        req_valid = 2'b11;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (req_ready != 2'b00) bad = 1'b1;
        end
        chk("post_rst_wait_busy", 32'(bad), 32'd0);
        @(posedge clk); #1;
        kill = 1'b1;
        hang = 1'b0;
        @(posedge clk); #1;
        kill = 1'b0;
        wait_acc(2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(13);
        if (acc_idx_q.size() >= 2) begin
            chk("post_rst_first_lane", 32'(acc_idx_q[0]), 32'd0);
            chk("post_rst_second_lane", 32'(acc_idx_q[1]), 32'd1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one sequential 8x8 multiplier (`mult`) between up to four requesters. Each requester submits operands over a valid/ready handshake, and the arbiter grants one request at a time. It pulses the multiplier's start, tracks its busy flag, captures the 16-bit product and returns it to the granted requester over a held valid/ready response channel. A watchdog ends any job whose busy flag never falls, returning an error response.

## Interface
- `N`, default 2: number of requesters, legal 1..4.
- `TIMEOUT`, default 32: maximum cycles spent in WAIT before forcing an error response, legal 16..255.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in N: request valid, one bit per requester.
- `req_ready_o` out N: request accepted; one-hot or zero.
- `req_a_i` in 8N: operand A; requester k uses bits [8k+7:8k].
- `req_b_i` in 8N: operand B, packed the same way as `req_a_i`.
- `rsp_valid_o` out N: response valid; one-hot or zero.
- `rsp_ready_i` in N: response accepted by the requester.
- `rsp_y_o` out 16: product, shared by all requesters.
- `rsp_err_o` out 1: response is a timeout error.
- `mult_start_o` out 1: drives `start_i` on `mult`.
- `mult_a_o` out 8: drives `a_bi` on `mult`.
- `mult_b_o` out 8: drives `b_bi` on `mult`.
- `mult_busy_i` in 1: from `busy_o` on `mult`.
- `mult_y_i` in 16: from `y_bo` on `mult`.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid_i` bit is set and `mult_busy_i`=0, grant requester g.
  - g is the first set valid bit searching upward (with wrap-around) from `ptr`+1. After reset `ptr`=N-1, so requester 0 has first priority.
  - Assert `req_ready_o[g]` combinationally for that cycle.
  - Latch A, B and g; set `ptr`<=g; go to ISSUE.
- **ISSUE:** `mult_start_o`=1 for exactly one cycle with the latched operands on `mult_a_o`/`mult_b_o`; go to WAIT and clear the watchdog counter.
- **WAIT:**
  - Increment the watchdog counter every cycle.
  - If `mult_busy_i`=0, capture `mult_y_i` into `rsp_y_o`, set `rsp_err_o`=0 and go to RESP.
  - Otherwise, if the counter reaches `TIMEOUT`-1, set `rsp_y_o`=0, set `rsp_err_o`=1 and go to RESP.
- **RESP:**
  - `rsp_valid_o[g]`=1; `rsp_y_o` and `rsp_err_o` are held stable.
  - When `rsp_ready_i[g]`=1, go to IDLE. The next grant is evaluated in IDLE, not in the same cycle.
- **Outside states:** `mult_a_o`/`mult_b_o` hold their last latched values; `mult_start_o`=0.
- **Busy guard:** no start is issued while `mult_busy_i`=1 in IDLE. This covers the case where the arbiter was reset while `mult` was mid-job, since `mult` has its own synchronous reset; the arbiter waits for busy to drop.
- **Non-granted requesters:** see `req_ready_o`=0. A requester may drop `req_valid_i` before it is granted without side effects.
- **Only one job in flight;** no queueing.
- **Arithmetic:** unsigned. The product is passed through unmodified.

## Timing
- **Reset values (all outputs):** `req_ready_o`=0, `rsp_valid_o`=0, `rsp_y_o`=0, `rsp_err_o`=0, `mult_start_o`=0, `mult_a_o`=0, `mult_b_o`=0.
- **Reset internals:** state=IDLE, `ptr`=N-1, watchdog counter=0.
- **Accept:** cycle 0 (IDLE, `req_ready_o[g]`=1).
- **Start:** cycle 1 (ISSUE, `mult_start_o`=1).
- **Multiply:** `mult_busy_i` is high in cycles 2..9. WAIT sees busy=0 in cycle 10 and captures the product at the end of that cycle.
- **Response:** `rsp_valid_o[g]` first high in cycle 11, which is 11 cycles after accept.
- **Throughput:** with `rsp_ready_i` held high, one job every 12 cycles.
- **Response backpressure:** `rsp_valid_o` stays high indefinitely until `rsp_ready_i` of the granted requester is high. Other `rsp_ready_i` bits are ignored.
- **Timeout:** measured from WAIT entry. Timeout response appears `TIMEOUT`+1 cycles after ISSUE.
- **Reset mid-operation:** `rst_ni` low forces all reset values immediately (asynchronous), and any pending response is dropped.

## Test plan
- **Single job:** N=2, requester 0 sends A=8'd13, B=8'd11 -> `req_ready_o`=01 at accept; `rsp_valid_o`=01 exactly 11 cycles later; `rsp_y_o`=16'd143, `rsp_err_o`=0.
- **Extremes:** A=B=8'hFF -> `rsp_y_o`=16'hFE01. A=0, B=8'hFF -> `rsp_y_o`=0.
- **Round-robin:** requesters 0 and 1 both hold valid continuously -> grants alternate 0,1,0,1; grants are 12 cycles apart with `rsp_ready_i`=11.
- **Backpressure:** hold `rsp_ready_i`=0 for 20 cycles after response -> `rsp_valid_o`/`rsp_y_o` stable; no new `mult_start_o`; the pending request from the other requester is granted the cycle after the response handshake.
- **Timeout:** stub holds `mult_busy_i`=1 forever -> `rsp_err_o`=1, `rsp_y_o`=0, `rsp_valid_o` asserted `TIMEOUT`+1 cycles after start. The next request is then not started until busy falls.
- **Reset mid-job:** assert `rst_ni`=0 during WAIT -> all outputs 0 asynchronously. After release, with the stub busy still high for 3 cycles, the first new start is issued only after busy drops.
